mmio_uart_tx: RTL and testbench
===============================

MMIO_UART_TX -- requirements
Module: mmio_uart_tx

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of the core data bus (wdata, rdata).
REQ-002 Parameter FIFO_DEPTH, default 4: number of TX FIFO entries; power of two, minimum 2.
REQ-003 Parameter BAUD_DIV_RST, default 234: reset value of BAUDDIV (27 MHz / 115200).
REQ-004 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-005 Port arst, input, 1: reset, asynchronous, active-high.
REQ-006 Port sel, input, 1: peripheral selected by the core's address decoder.
REQ-007 Port addr, input, 2: word offset; 0 TXDATA, 1 STATUS, 2 BAUDDIV, 3 reserved.
REQ-008 Port we, input, 1: store strobe, qualified by sel.
REQ-009 Port wdata, input, DATA_WIDTH: store data.
REQ-010 Port rdata, output, DATA_WIDTH: combinational read data for the addressed register.
REQ-011 Port tx, output, 1: serial line; idles high.
REQ-012 Port irq_empty, output, 1: high while the FIFO is empty and the serializer is in IDLE.

Function
REQ-013 A write (sel&we) to TXDATA SHALL push wdata[7:0] into the FIFO on that edge when count < FIFO_DEPTH.
REQ-014 A TXDATA write while count == FIFO_DEPTH SHALL drop the data and set sticky OVF; fullness is judged on the pre-edge count, even if a pop occurs on the same edge.
REQ-015 STATUS read layout: bit0 FULL, bit1 EMPTY, bit2 BUSY (serializer not IDLE), bit3 OVF, bits[7:4] count; all other bits 0.
REQ-016 Any write to STATUS SHALL clear OVF; the other STATUS bits are read-only.
REQ-017 BAUDDIV SHALL be read/write with bits[15:0] valid; a written value of 0 SHALL be stored as 1; reads SHALL return the stored value zero-extended.
REQ-018 Reads of offset 3, or any read with sel low, SHALL return 0.
REQ-019 Serializer FSM states: IDLE, START, DATA, PARITY (present only when configured), STOP.
REQ-020 In IDLE with the FIFO non-empty, the FSM SHALL pop the head into a shift register and enter START on the same edge; tx SHALL go low on the following cycle.
REQ-021 Each bit period SHALL last exactly BAUDDIV clocks, timed by a down-counter reloaded at every state or bit change.
REQ-022 DATA SHALL send 8 bits LSB first; STOP SHALL hold tx high for one bit period, then return to IDLE.
REQ-023 Back-to-back frames: when the FIFO is non-empty at the end of STOP, the next START SHALL follow with no idle bit.
REQ-024 BAUDDIV writes during a frame SHALL take effect at the next bit-counter reload.
REQ-025 FIFO pointers SHALL wrap modulo FIFO_DEPTH; count SHALL range 0..FIFO_DEPTH; a push and a pop on the same edge SHALL leave count unchanged.

Reset
REQ-026 While arst is high: tx=1, FSM=IDLE, FIFO empty (pointers and count 0), OVF=0, BAUDDIV=BAUD_DIV_RST, irq_empty=1.
REQ-027 Reset asserted mid-frame SHALL abort the frame immediately; tx SHALL be high on the same cycle and no partial frame SHALL resume.

Configuration
REQ-028 Macro UART_TX_PARITY_EN: when defined, the FSM SHALL insert a PARITY state after DATA that transmits even parity (XOR of the 8 data bits) for one bit period; when undefined, the PARITY state and its logic SHALL be absent and DATA SHALL proceed directly to STOP.

Verification
REQ-029 Reset, BAUDDIV=4, write TXDATA=0x55 -> tx: low 4 clk, then 1,0,1,0,1,0,1,0 at 4 clk each, high 4 clk; total frame 40 clk; irq_empty returns to 1.
REQ-030 Five TXDATA writes on consecutive cycles with FSM busy and FIFO_DEPTH=4 -> fifth write dropped, STATUS=0x4D (count 4, OVF, BUSY, FULL); a STATUS write then reads OVF=0.
REQ-031 Two queued bytes 0xA0,0x0F -> second start bit begins on the cycle after the first stop bit ends; no idle gap.
REQ-032 UART_TX_PARITY_EN defined, byte 0x07 at BAUDDIV=2 -> parity bit 1, frame 22 clk; undefined -> frame 20 clk.
REQ-033 arst pulsed during DATA bit 3 -> tx high on the same cycle, STATUS=0x02, BAUDDIV reads 234, no further transitions on tx.
REQ-034 Write BAUDDIV=0 -> reads back 1; a frame then takes 10 clk.

Source files
------------

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx -- memory-mapped UART transmitter with a small TX FIFO.
//
// Register map (word offset on addr):
//   0 TXDATA  (W)  : wdata[7:0] is queued for transmission; it is dropped and
//                    OVF is set if the FIFO is already full
//   1 STATUS  (R/W): [0] FULL [1] EMPTY [2] BUSY [3] OVF [7:4] count;
//                    any write clears OVF
//   2 BAUDDIV (R/W): [15:0] clocks per bit; a written 0 is stored as 1
//   3 reserved     : reads 0
//
// Ports:
//   clk       : single clock, rising edge
//   arst      : asynchronous active-high reset
//   sel       : peripheral select from the address decoder
//   addr[1:0] : register word offset
//   we        : store strobe (qualified by sel)
//   wdata     : store data (DATA_WIDTH)
//   rdata     : combinational read data, 0 when sel is low
//   tx        : serial line, idles high
//   irq_empty : high while the FIFO is empty and the serializer is idle
//
// Frame: start bit, 8 data bits LSB first, optional even parity, one stop bit.
// Define UART_TX_PARITY_EN to include the parity bit.
// DATA_WIDTH must be at least 16 so that BAUDDIV fits on the bus.

module mmio_uart_tx #(
    parameter int DATA_WIDTH   = 32,
    parameter int FIFO_DEPTH   = 4,
    parameter int BAUD_DIV_RST = 234
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic                  sel,
    input  logic [1:0]            addr,
    input  logic                  we,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  tx,
    output logic                  irq_empty
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [15:0]   BAUD_RST = 16'(BAUD_DIV_RST);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    // A divider of 0 would stall the bit counter, so it is promoted to 1.
    function automatic logic [15:0] clamp_div(input logic [15:0] v);
        return (v == 16'd0) ? 16'd1 : v;
    endfunction

    state_t          state_q, state_d;
    logic [15:0]     baud_div_q;
    logic [15:0]     baud_cnt_q;
    logic [2:0]      bit_idx_q;
    logic            ovf_q;
    logic [7:0]      mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic [7:0]      shreg_q;
`ifdef UART_TX_PARITY_EN
    logic            parity_q;
`endif

    logic wr_txdata, wr_status, wr_baud;
    logic full, empty, push, pop, reload, shift, bit_end, busy;
    logic [7:0] status;
    logic unused_wdata_hi;

    assign wr_txdata = sel && we && (addr == 2'd0);
    assign wr_status = sel && we && (addr == 2'd1);
    assign wr_baud   = sel && we && (addr == 2'd2);

    // Fullness is judged on the pre-edge count, so a pop on the same edge
    // does not rescue a write into a full FIFO.
    assign full    = (count_q == DEPTH_C);
    assign empty   = (count_q == '0);
    assign push    = wr_txdata && !full;
    assign bit_end = (baud_cnt_q == 16'd0);
    assign busy    = (state_q != IDLE);

    assign irq_empty       = empty && !busy;
    assign unused_wdata_hi = ^wdata[DATA_WIDTH-1:16];

    // Next-state logic: a pop always coincides with entering START, so the
    // bit counter and bit index are reloaded there as well.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        reload  = 1'b0;
        shift   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    reload  = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) begin
                    reload  = 1'b1;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    reload = 1'b1;
                    shift  = 1'b1;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    reload  = 1'b1;
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    // Chain straight into the next start bit when more data waits.
                    if (!empty) begin
                        pop     = 1'b1;
                        reload  = 1'b1;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Line level is decoded from the state register so reset forces it high
    // in the same cycle.
    always_comb begin
        tx = 1'b1;
        case (state_q)
            START:   tx = 1'b0;
            DATA:    tx = shreg_q[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx = parity_q;
`endif
            default: tx = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q    <= IDLE;
            baud_div_q <= BAUD_RST;
            baud_cnt_q <= 16'd0;
            bit_idx_q  <= 3'd0;
            ovf_q      <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q <= state_d;

            // Reload samples the current BAUDDIV, so divider writes apply at
            // the next bit boundary.
            if (reload)
                baud_cnt_q <= baud_div_q - 16'd1;
            else if (!bit_end)
                baud_cnt_q <= baud_cnt_q - 16'd1;

            if (pop)
                bit_idx_q <= 3'd0;
            else if (shift)
                bit_idx_q <= bit_idx_q + 3'd1;

            if (wr_baud)
                baud_div_q <= clamp_div(wdata[15:0]);

            if (wr_txdata && full)
                ovf_q <= 1'b1;
            else if (wr_status)
                ovf_q <= 1'b0;

            if (push)
                wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)
                rd_ptr_q <= rd_ptr_q + PW'(1);

            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr_q] <= wdata[7:0];
        if (pop) begin
            shreg_q <= mem[rd_ptr_q];
`ifdef UART_TX_PARITY_EN
            parity_q <= ^mem[rd_ptr_q];
`endif
        end else if (shift) begin
            shreg_q <= {1'b0, shreg_q[7:1]};
        end
    end

    assign status = {4'(count_q), ovf_q, busy, empty, full};

    always_comb begin
        rdata = '0;
        if (sel) begin
            case (addr)
                2'd1:    rdata[7:0]  = status;
                2'd2:    rdata[15:0] = baud_div_q;
                default: rdata       = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
module tb_mmio_uart_tx;

    logic        clk = 1'b0;
    logic        arst = 1'b0;
    logic        sel = 1'b0;
    logic [1:0]  addr = 2'd0;
    logic        we = 1'b0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] rdata;
    logic        tx;
    logic        irq_empty;

    int errors = 0;
    int checks = 0;

    logic [15:0] div_m;
    logic [7:0]  bytes_q[$];
    bit          exp_tx[$];
    bit          exp_irq[$];
    logic [31:0] rv;

    mmio_uart_tx #(
        .DATA_WIDTH  (32),
        .FIFO_DEPTH  (4),
        .BAUD_DIV_RST(234)
    ) dut (
        .clk      (clk),
        .arst     (arst),
        .sel      (sel),
        .addr     (addr),
        .we       (we),
        .wdata    (wdata),
        .rdata    (rdata),
        .tx       (tx),
        .irq_empty(irq_empty)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        sel = 1'b1; we = 1'b1; addr = a; wdata = d;
        @(posedge clk);
        #1;
        sel = 1'b0; we = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        sel = 1'b1; we = 1'b0; addr = a;
        #1;
        d = rdata;
        sel = 1'b0;
    endtask

    // Reference line waveform of one frame: each symbol held for div_m clocks.
    task automatic add_frame(input logic [7:0] b);
        bit sym[$];
        sym.push_back(1'b0);
        for (int i = 0; i < 8; i++) sym.push_back(b[i]);
`ifdef UART_TX_PARITY_EN
        sym.push_back(^b);
`endif
        sym.push_back(1'b1);
        foreach (sym[s])
            for (int c = 0; c < int'(div_m); c++) begin
                exp_tx.push_back(sym[s]);
                exp_irq.push_back(1'b0);
            end
    endtask

    // Writes bytes_q to TXDATA on consecutive edges while comparing the line
    // every cycle against the concatenated reference frames.
    task automatic run_burst(input string tag);
        int i;
        int n;
        int idx;
        n = bytes_q.size();
        exp_tx.delete();
        exp_irq.delete();
        exp_tx.push_back(1'b1);
        exp_irq.push_back(1'b0);
        foreach (bytes_q[k]) add_frame(bytes_q[k]);
        for (int k = 0; k < 2; k++) begin
            exp_tx.push_back(1'b1);
            exp_irq.push_back(1'b1);
        end
        i = 0;
        idx = 0;
        while (exp_tx.size() > 0) begin
            @(negedge clk);
            if (i >= 1) begin
                check($sformatf("%s tx@%0d", tag, idx), 32'(tx), 32'(exp_tx.pop_front()));
                check($sformatf("%s irq@%0d", tag, idx), 32'(irq_empty), 32'(exp_irq.pop_front()));
                idx++;
            end
            if (i < n) begin
                sel = 1'b1; we = 1'b1; addr = 2'd0; wdata = {24'd0, bytes_q[i]};
            end else begin
                sel = 1'b0; we = 1'b0;
            end
            i++;
        end
        sel = 1'b0; we = 1'b0;
        rd(2'd1, rv);
        check({tag, " status_after"}, rv, 32'h02);
    endtask

    initial begin
        int n_wait;
        bit seen_low;

        // Reset state
        #1 arst = 1'b1;
        #2;
        check("rst tx", 32'(tx), 32'd1);
        check("rst irq", 32'(irq_empty), 32'd1);
        rd(2'd1, rv);
        check("rst status", rv, 32'h02);
        rd(2'd2, rv);
        check("rst bauddiv", rv, 32'd234);
        @(negedge clk);
        arst = 1'b0;

        // Read decoding
        rd(2'd3, rv);
        check("rd reserved", rv, 32'd0);
        @(negedge clk);
        sel = 1'b0; addr = 2'd2;
        #1;
        check("rd unselected", rdata, 32'd0);

        // Divider 0 promoted to 1; 10-clock frame
        wr(2'd2, 32'hFFFF_0000);
        rd(2'd2, rv);
        check("bauddiv zero", rv, 32'd1);
        div_m = 16'd1;
        bytes_q = '{8'h3C};
        run_burst("div1");

        // Divider 4, byte 0x55
        wr(2'd2, 32'd4);
        rd(2'd2, rv);
        check("bauddiv 4", rv, 32'd4);
        div_m = 16'd4;
        bytes_q = '{8'h55};
        run_burst("b55");

        // Back-to-back frames
        bytes_q = '{8'hA0, 8'h0F};
        run_burst("b2b");

        // Divider 2, byte 0x07 (parity frame when enabled)
        wr(2'd2, 32'd2);
        div_m = 16'd2;
        bytes_q = '{8'h07};
        run_burst("b07");

        // Overflow while the serializer is busy
        wr(2'd2, 32'd4);
        wr(2'd0, 32'h11);
        repeat (2) @(posedge clk);
        for (int k = 0; k < 5; k++) wr(2'd0, 32'h20 + k);
        rd(2'd1, rv);
        check("ovf status", rv, 32'h4D);
        wr(2'd1, 32'hFFFF_FFFF);
        rd(2'd1, rv);
        check("ovf cleared", rv, 32'h45);
        n_wait = 0;
        while (!irq_empty && n_wait < 400) begin
            @(negedge clk);
            n_wait++;
        end
        check("ovf drain", 32'(irq_empty), 32'd1);

        // Randomized bursts
        for (int it = 0; it < 6; it++) begin
            int k;
            div_m = 16'($urandom_range(1, 5));
            wr(2'd2, {16'd0, div_m});
            bytes_q.delete();
            k = $urandom_range(1, 4);
            for (int j = 0; j < k; j++) bytes_q.push_back(8'($urandom_range(0, 255)));
            run_burst($sformatf("rnd%0d", it));
        end

        // Reset during data bit 3
        wr(2'd2, 32'd4);
        wr(2'd0, 32'hF7);
        repeat (18) @(posedge clk);
        @(negedge clk);
        check("mid bit3", 32'(tx), 32'd0);
        arst = 1'b1;
        #1;
        check("mid rst tx", 32'(tx), 32'd1);
        check("mid rst irq", 32'(irq_empty), 32'd1);
        rd(2'd1, rv);
        check("mid rst status", rv, 32'h02);
        rd(2'd2, rv);
        check("mid rst bauddiv", rv, 32'd234);
        @(negedge clk);
        arst = 1'b0;
        seen_low = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (tx !== 1'b1) seen_low = 1'b1;
        end
        check("mid no resume", 32'(seen_low), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
